// File: rtl/bob_queue.sv
// Branch order buffer: a circular queue with one checkpoint per predicted
// conditional branch. It hands the stored predictor metadata back on a
// mispredict (history repair) and on in-order retirement (table update).
//
// Handshakes: alloc_valid_i / alloc_ready_o is a strict valid/ready pair. An
// entry is written only in a cycle where both are high. alloc_ready_o is
// combinational and never depends on alloc_valid_i. A dropped allocation
// leaves no state behind, and fetch presents it again. rt_req_i / rt_ack_o
// works the same way: the head retires only in a cycle where rt_ack_o is high.
module bob_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             alloc_valid_i,
    input  logic [63:0]      alloc_pc_i,
    input  logic [11:0]      alloc_bhr_i,
    input  logic [9:0]       alloc_lochist_i,
    input  logic             alloc_pred_i,
    input  logic             alloc_ch_we_i,
    input  logic             alloc_ch_ud_i,
    output logic             alloc_ready_o,
    output logic [PTR_W-1:0] alloc_tag_o,
    input  logic             res_valid_i,
    input  logic [PTR_W-1:0] res_tag_i,
    input  logic             res_brdir_i,
    input  logic             flush_i,
    input  logic             rt_req_i,
    output logic             rt_ack_o,
    output logic [PTR_W:0]   count_o,
    output logic [63:0]      bob_pc_r_o,
    output logic [11:0]      bob_bhr_r_o,
    output logic [9:0]       bob_lochist_o,
    output logic             bob_valid_r_o,
    output logic             bob_flush_o,
    output logic             bpd_rt_we_o,
    output logic             bpd_rt_update_o,
    output logic             bpd_rt_brdir_o,
    output logic             bpd_ch_we_o,
    output logic             bpd_ch_brdir_o
);

    // Pointers carry an extra wrap bit so that full and empty are distinct.
    logic [PTR_W:0]   head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d, resolved_q, resolved_d;

    // Checkpoint payload. It needs no reset because valid_q gates every use.
    logic [63:0]      pc_mem      [DEPTH];
    logic [11:0]      bhr_mem     [DEPTH];
    logic [9:0]       lochist_mem [DEPTH];
    logic [DEPTH-1:0] pred_mem, ch_we_mem, ch_ud_mem, dir_mem;

    // Registered report bus to the predictor.
    logic [63:0] rep_pc_q, rep_pc_d;
    logic [11:0] rep_bhr_q, rep_bhr_d;
    logic [9:0]  rep_lochist_q, rep_lochist_d;
    logic        rep_valid_q, rep_valid_d;
    logic        rep_flush_q, rep_flush_d;
    logic        rt_upd_q, rt_upd_d;
    logic        rt_dir_q, rt_dir_d;
    logic        ch_we_q, ch_we_d;
    logic        ch_ud_q, ch_ud_d;

    logic [PTR_W-1:0] head_idx, tail_idx, res_rel;
    logic             full, res_hit, mispredict_now, alloc_fire;
    logic [DEPTH-1:0] younger;

    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);
    assign count_o  = tail_q - head_q;

    // A resolve to a squashed (invalid) tag is ignored completely.
    assign res_hit        = res_valid_i & valid_q[res_tag_i];
    assign mispredict_now = res_hit & (res_brdir_i != pred_mem[res_tag_i]);

    assign alloc_ready_o = ~full & ~mispredict_now & ~flush_i;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;
    assign alloc_tag_o   = tail_idx;

    // The resolved bit is registered, so a resolve and a retire of the same entry in one cycle cannot ack.
    assign rt_ack_o = rt_req_i & valid_q[head_idx] & resolved_q[head_idx]
                      & ~mispredict_now & ~flush_i;

    // Position of the resolving branch relative to the head (age order).
    assign res_rel = res_tag_i - head_idx;

    // Mark every slot that is younger than the resolving branch.
    for (genvar g = 0; g < DEPTH; g++) begin : g_younger
        assign younger[g] = (PTR_W'(g) - head_idx) > res_rel;
    end

    // Next-state for the pointers, per-entry flags and report bus. Priority is flush > mispredict > retire.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        valid_d       = valid_q;
        resolved_d    = resolved_q;
        rep_pc_d      = '0;
        rep_bhr_d     = '0;
        rep_lochist_d = '0;
        rep_valid_d   = 1'b0;
        rep_flush_d   = 1'b0;
        rt_upd_d      = 1'b0;
        rt_dir_d      = 1'b0;
        ch_we_d       = 1'b0;
        ch_ud_d       = 1'b0;

        if (flush_i) begin
            head_d      = '0;
            tail_d      = '0;
            valid_d     = '0;
            resolved_d  = '0;
            rep_flush_d = 1'b1;
        end else begin
            if (res_hit) begin
                resolved_d[res_tag_i] = 1'b1;
            end

            if (mispredict_now) begin
                // Truncate the queue just after the mispredicted branch. The wrap bit follows from the head.
                tail_d        = head_q + {1'b0, res_rel} + (PTR_W+1)'(1);
                valid_d       = valid_d & ~younger;
                resolved_d    = resolved_d & ~younger;
                rep_flush_d   = 1'b1;
                rep_valid_d   = 1'b1;
                rep_pc_d      = pc_mem[res_tag_i];
                rep_bhr_d     = {bhr_mem[res_tag_i][10:0], res_brdir_i};
                rep_lochist_d = lochist_mem[res_tag_i];
            end else begin
                if (rt_ack_o) begin
                    valid_d[head_idx] = 1'b0;
                    head_d            = head_q + (PTR_W+1)'(1);
                    rep_pc_d          = pc_mem[head_idx];
                    rep_bhr_d         = bhr_mem[head_idx];
                    rep_lochist_d     = lochist_mem[head_idx];
                    rt_upd_d          = 1'b1;
                    rt_dir_d          = dir_mem[head_idx];
                    ch_we_d           = ch_we_mem[head_idx];
                    ch_ud_d           = ch_ud_mem[head_idx];
                end
                if (alloc_fire) begin
                    valid_d[tail_idx]    = 1'b1;
                    resolved_d[tail_idx] = 1'b0;
                    tail_d               = tail_q + (PTR_W+1)'(1);
                end
            end
        end
    end

    // Control state and report registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            valid_q       <= '0;
            resolved_q    <= '0;
            rep_pc_q      <= '0;
            rep_bhr_q     <= '0;
            rep_lochist_q <= '0;
            rep_valid_q   <= 1'b0;
            rep_flush_q   <= 1'b0;
            rt_upd_q      <= 1'b0;
            rt_dir_q      <= 1'b0;
            ch_we_q       <= 1'b0;
            ch_ud_q       <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            valid_q       <= valid_d;
            resolved_q    <= resolved_d;
            rep_pc_q      <= rep_pc_d;
            rep_bhr_q     <= rep_bhr_d;
            rep_lochist_q <= rep_lochist_d;
            rep_valid_q   <= rep_valid_d;
            rep_flush_q   <= rep_flush_d;
            rt_upd_q      <= rt_upd_d;
            rt_dir_q      <= rt_dir_d;
            ch_we_q       <= ch_we_d;
            ch_ud_q       <= ch_ud_d;
        end
    end

    // Checkpoint payload writes on accepted allocations and on real resolves.
    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            pc_mem[tail_idx]      <= alloc_pc_i;
            bhr_mem[tail_idx]     <= alloc_bhr_i;
            lochist_mem[tail_idx] <= alloc_lochist_i;
            pred_mem[tail_idx]    <= alloc_pred_i;
            ch_we_mem[tail_idx]   <= alloc_ch_we_i;
            ch_ud_mem[tail_idx]   <= alloc_ch_ud_i;
        end
        if (res_hit && !flush_i) begin
            dir_mem[res_tag_i] <= res_brdir_i;
        end
    end

    assign bob_pc_r_o      = rep_pc_q;
    assign bob_bhr_r_o     = rep_bhr_q;
    assign bob_lochist_o   = rep_lochist_q;
    assign bob_valid_r_o   = rep_valid_q;
    assign bob_flush_o     = rep_flush_q;
    assign bpd_rt_we_o     = rt_upd_q;
    assign bpd_rt_update_o = rt_upd_q;
    assign bpd_rt_brdir_o  = rt_dir_q;
    assign bpd_ch_we_o     = ch_we_q;
    assign bpd_ch_brdir_o  = ch_ud_q;

endmodule

// File: tb/tb_bob_queue.sv
// Directed bench for bob_queue. Each table row describes one clock cycle:
// the inputs, the combinational outputs expected during that cycle, and the
// registered report expected just after its rising edge.
module tb_bob_queue;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             alloc_valid_i;
    logic [63:0]      alloc_pc_i;
    logic [11:0]      alloc_bhr_i;
    logic [9:0]       alloc_lochist_i;
    logic             alloc_pred_i, alloc_ch_we_i, alloc_ch_ud_i;
    logic             alloc_ready_o;
    logic [PTR_W-1:0] alloc_tag_o;
    logic             res_valid_i;
    logic [PTR_W-1:0] res_tag_i;
    logic             res_brdir_i;
    logic             flush_i, rt_req_i, rt_ack_o;
    logic [PTR_W:0]   count_o;
    logic [63:0]      bob_pc_r_o;
    logic [11:0]      bob_bhr_r_o;
    logic [9:0]       bob_lochist_o;
    logic             bob_valid_r_o, bob_flush_o;
    logic             bpd_rt_we_o, bpd_rt_update_o, bpd_rt_brdir_o;
    logic             bpd_ch_we_o, bpd_ch_brdir_o;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    bob_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i),
        .alloc_bhr_i(alloc_bhr_i), .alloc_lochist_i(alloc_lochist_i),
        .alloc_pred_i(alloc_pred_i), .alloc_ch_we_i(alloc_ch_we_i),
        .alloc_ch_ud_i(alloc_ch_ud_i), .alloc_ready_o(alloc_ready_o),
        .alloc_tag_o(alloc_tag_o), .res_valid_i(res_valid_i),
        .res_tag_i(res_tag_i), .res_brdir_i(res_brdir_i),
        .flush_i(flush_i), .rt_req_i(rt_req_i), .rt_ack_o(rt_ack_o),
        .count_o(count_o), .bob_pc_r_o(bob_pc_r_o), .bob_bhr_r_o(bob_bhr_r_o),
        .bob_lochist_o(bob_lochist_o), .bob_valid_r_o(bob_valid_r_o),
        .bob_flush_o(bob_flush_o), .bpd_rt_we_o(bpd_rt_we_o),
        .bpd_rt_update_o(bpd_rt_update_o), .bpd_rt_brdir_o(bpd_rt_brdir_o),
        .bpd_ch_we_o(bpd_ch_we_o), .bpd_ch_brdir_o(bpd_ch_brdir_o)
    );

    // ---------------- vector record ----------------
    typedef struct packed {
        logic        av;
        logic [63:0] pc;
        logic [11:0] bhr;
        logic [9:0]  lh;
        logic        pred, chwe, chud;
        logic        rv;
        logic [3:0]  rtag;
        logic        rdir, fl, rq;
        logic        e_rdy;
        logic [3:0]  e_tag;
        logic        e_ack;
        logic [4:0]  e_cnt;
        logic        e_fl, e_vr;
        logic [63:0] e_pc;
        logic [11:0] e_bhr;
        logic [9:0]  e_lh;
        logic        e_upd, e_dir, e_chwe, e_chud;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t idle(input logic [3:0] tag, input logic [4:0] cnt);
        vec_t v;
        v       = '0;
        v.e_rdy = 1'b1;
        v.e_tag = tag;
        v.e_cnt = cnt;
        return v;
    endfunction

    function automatic vec_t alloc_r(input logic [3:0] tag, input logic [4:0] cnt,
                                     input logic [63:0] pc, input logic [11:0] bhr,
                                     input logic [9:0] lh, input logic pred,
                                     input logic chwe, input logic chud);
        vec_t v;
        v      = idle(tag, cnt);
        v.av   = 1'b1;
        v.pc   = pc;
        v.bhr  = bhr;
        v.lh   = lh;
        v.pred = pred;
        v.chwe = chwe;
        v.chud = chud;
        return v;
    endfunction

    function automatic vec_t res_r(input logic [3:0] tag, input logic [4:0] cnt,
                                   input logic [3:0] rtag, input logic rdir);
        vec_t v;
        v      = idle(tag, cnt);
        v.rv   = 1'b1;
        v.rtag = rtag;
        v.rdir = rdir;
        return v;
    endfunction

    function automatic vec_t retire(input vec_t vin, input logic [63:0] pc,
                                    input logic [11:0] bhr, input logic [9:0] lh,
                                    input logic dir, input logic chwe, input logic chud);
        vec_t v;
        v        = vin;
        v.e_ack  = 1'b1;
        v.e_upd  = 1'b1;
        v.e_pc   = pc;
        v.e_bhr  = bhr;
        v.e_lh   = lh;
        v.e_dir  = dir;
        v.e_chwe = chwe;
        v.e_chud = chud;
        return v;
    endfunction

    function automatic vec_t mispred(input vec_t vin, input logic [63:0] pc,
                                     input logic [11:0] bhr, input logic [9:0] lh);
        vec_t v;
        v       = vin;
        v.e_rdy = 1'b0;
        v.e_fl  = 1'b1;
        v.e_vr  = 1'b1;
        v.e_pc  = pc;
        v.e_bhr = bhr;
        v.e_lh  = lh;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        alloc_valid_i   = 1'b0;
        alloc_pc_i      = '0;
        alloc_bhr_i     = '0;
        alloc_lochist_i = '0;
        alloc_pred_i    = 1'b0;
        alloc_ch_we_i   = 1'b0;
        alloc_ch_ud_i   = 1'b0;
        res_valid_i     = 1'b0;
        res_tag_i       = '0;
        res_brdir_i     = 1'b0;
        flush_i         = 1'b0;
        rt_req_i        = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic apply(input vec_t v, input string lbl);
        alloc_valid_i   = v.av;
        alloc_pc_i      = v.pc;
        alloc_bhr_i     = v.bhr;
        alloc_lochist_i = v.lh;
        alloc_pred_i    = v.pred;
        alloc_ch_we_i   = v.chwe;
        alloc_ch_ud_i   = v.chud;
        res_valid_i     = v.rv;
        res_tag_i       = v.rtag;
        res_brdir_i     = v.rdir;
        flush_i         = v.fl;
        rt_req_i        = v.rq;
        #2;
        chk({lbl, " alloc_ready"}, 64'(alloc_ready_o), 64'(v.e_rdy));
        chk({lbl, " alloc_tag"},   64'(alloc_tag_o),   64'(v.e_tag));
        chk({lbl, " rt_ack"},      64'(rt_ack_o),      64'(v.e_ack));
        chk({lbl, " count"},       64'(count_o),       64'(v.e_cnt));
        @(posedge clock);
        #1;
        chk({lbl, " bob_flush"},   64'(bob_flush_o),     64'(v.e_fl));
        chk({lbl, " bob_valid_r"}, 64'(bob_valid_r_o),   64'(v.e_vr));
        chk({lbl, " bob_pc"},      bob_pc_r_o,           v.e_pc);
        chk({lbl, " bob_bhr"},     64'(bob_bhr_r_o),     64'(v.e_bhr));
        chk({lbl, " bob_lochist"}, 64'(bob_lochist_o),   64'(v.e_lh));
        chk({lbl, " rt_we"},       64'(bpd_rt_we_o),     64'(v.e_upd));
        chk({lbl, " rt_update"},   64'(bpd_rt_update_o), 64'(v.e_upd));
        chk({lbl, " rt_brdir"},    64'(bpd_rt_brdir_o),  64'(v.e_dir));
        chk({lbl, " ch_we"},       64'(bpd_ch_we_o),     64'(v.e_chwe));
        chk({lbl, " ch_brdir"},    64'(bpd_ch_brdir_o),  64'(v.e_chud));
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        reset_n = 1'b0;
        drive_idle();
        #1;
        chk("reset count",     64'(count_o),         64'd0);
        chk("reset alloc_tag", 64'(alloc_tag_o),     64'd0);
        chk("reset rt_ack",    64'(rt_ack_o),        64'd0);
        chk("reset bob_flush", 64'(bob_flush_o),     64'd0);
        chk("reset valid_r",   64'(bob_valid_r_o),   64'd0);
        chk("reset pc",        bob_pc_r_o,           64'd0);
        chk("reset rt_update", 64'(bpd_rt_update_o), 64'd0);
        #11;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post-reset alloc_ready", 64'(alloc_ready_o), 64'd1);

        // Retire ordering: the head must be resolved first.
        tbl.push_back(alloc_r(0, 0, 64'h1000, 12'h0A5, 10'h011, 1, 0, 1));
        tbl.push_back(alloc_r(1, 1, 64'h1004, 12'h0A5, 10'h012, 1, 0, 1));
        tbl.push_back(alloc_r(2, 2, 64'h1008, 12'h0A5, 10'h013, 1, 1, 0));
        v = res_r(3, 3, 1, 1); v.rq = 1; tbl.push_back(v);
        v = idle(3, 3); v.rq = 1; tbl.push_back(v);
        v = res_r(3, 3, 0, 1); v.rq = 1; tbl.push_back(v);
        v = idle(3, 3); v.rq = 1; tbl.push_back(retire(v, 64'h1000, 12'h0A5, 10'h011, 1, 0, 1));
        v = idle(3, 2); v.rq = 1; tbl.push_back(retire(v, 64'h1004, 12'h0A5, 10'h012, 1, 0, 1));
        v = idle(3, 1); v.rq = 1; tbl.push_back(v);
        tbl.push_back(res_r(3, 1, 2, 1));
        v = idle(3, 1); v.rq = 1; tbl.push_back(retire(v, 64'h1008, 12'h0A5, 10'h013, 1, 1, 0));
        // Resolve of a retired (invalid) tag with a wrong direction does nothing.
        tbl.push_back(res_r(3, 0, 1, 0));
        tbl.push_back(idle(3, 0));

        // Flush with five entries, a retire request, an alloc and a resolve in the same cycle.
        for (int k = 0; k < 5; k++)
            tbl.push_back(alloc_r(4'(3 + k), 5'(k), 64'h2000 + 64'(4 * k), 12'h0A5,
                                  10'h020 + 10'(k), 1, 0, 0));
        tbl.push_back(res_r(8, 5, 3, 1));
        v = idle(8, 5); v.av = 1; v.fl = 1; v.rq = 1; v.rv = 1; v.rtag = 4;
        v.e_rdy = 0; v.e_fl = 1; tbl.push_back(v);
        tbl.push_back(idle(0, 0));

        // Mispredict recovery truncates the queue after tag 2.
        for (int k = 0; k < 6; k++)
            tbl.push_back(alloc_r(4'(k), 5'(k), 64'h3000 + 64'(4 * k), 12'h100 + 12'(k),
                                  10'h200 + 10'(k), 1, 0, 0));
        tbl.push_back(mispred(res_r(6, 6, 2, 0), 64'h3008, 12'h204, 10'h202));
        tbl.push_back(idle(3, 3));
        tbl.push_back(alloc_r(3, 3, 64'h3100, 12'h0A5, 10'h0AA, 1, 0, 0));
        tbl.push_back(res_r(4, 4, 4, 0));
        v = idle(4, 4); v.fl = 1; v.e_rdy = 0; v.e_fl = 1; tbl.push_back(v);
        tbl.push_back(idle(0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Fill to full, drop an alloc, retire one, then wrap the tail.
        for (int k = 0; k < DEPTH; k++)
            apply(alloc_r(4'(k), 5'(k), 64'h4000 + 64'(4 * k), 12'h0A5, 10'(k), 1, 0, 0),
                  $sformatf("fill%0d", k));
        v = idle(0, 16); v.av = 1; v.pc = 64'hDEAD; v.e_rdy = 0; apply(v, "full drop");
        v = res_r(0, 16, 0, 1); v.e_rdy = 0; apply(v, "full resolve");
        v = idle(0, 16); v.rq = 1; v.e_rdy = 0;
        apply(retire(v, 64'h4000, 12'h0A5, 10'h000, 1, 0, 0), "full retire");
        apply(alloc_r(0, 15, 64'h5000, 12'h0A5, 10'h055, 1, 0, 0), "wrap alloc");
        v = idle(1, 16); v.e_rdy = 0; apply(v, "wrap full");
        v = idle(1, 16); v.fl = 1; v.e_rdy = 0; v.e_fl = 1; apply(v, "wrap flush");
        apply(idle(0, 0), "wrap empty");

        // Mispredict and alloc in the same cycle: the alloc is dropped.
        apply(alloc_r(0, 0, 64'h6000, 12'h0F0, 10'h001, 1, 0, 0), "mp a0");
        apply(alloc_r(1, 1, 64'h6004, 12'h0F1, 10'h002, 1, 0, 0), "mp a1");
        apply(alloc_r(2, 2, 64'h6008, 12'h0F2, 10'h003, 1, 0, 0), "mp a2");
        v = res_r(3, 3, 1, 0); v.av = 1; v.pc = 64'h600C; v.pred = 1;
        apply(mispred(v, 64'h6004, 12'h1E2, 10'h002), "mp+alloc");
        apply(idle(2, 2), "mp tail");
        apply(alloc_r(2, 2, 64'h7000, 12'h0A5, 10'h004, 1, 0, 0), "mp realloc");

        // Reset mid-operation, while a mispredict is being presented.
        res_valid_i = 1'b1;
        res_tag_i   = 4'd0;
        res_brdir_i = 1'b0;
        rt_req_i    = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst count",       64'(count_o),       64'd0);
        chk("midrst alloc_tag",   64'(alloc_tag_o),   64'd0);
        chk("midrst rt_ack",      64'(rt_ack_o),      64'd0);
        chk("midrst alloc_ready", 64'(alloc_ready_o), 64'd1);
        @(posedge clock);
        #1;
        chk("midrst bob_flush", 64'(bob_flush_o),   64'd0);
        chk("midrst valid_r",   64'(bob_valid_r_o), 64'd0);
        drive_idle();
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("postrst bob_flush", 64'(bob_flush_o),     64'd0);
        chk("postrst rt_update", 64'(bpd_rt_update_o), 64'd0);
        chk("postrst count",     64'(count_o),         64'd0);
        apply(alloc_r(0, 0, 64'h8000, 12'h0A5, 10'h005, 1, 0, 0), "postrst alloc");
        apply(idle(1, 1), "postrst idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bob_queue.md
Name: bob_queue

Overview:
- Branch order buffer: circular queue holding one checkpoint per predicted conditional branch, allocated at fetch stage f1 in program order.
- Each checkpoint stores PC, global history (BHR), local history and choice metadata.
- Returns that metadata to the tournament predictor on two events:
  - mispredict recovery: history repair;
  - in-order retirement: non-speculative table update.
- Sits between fetch/predictor, branch execute unit and retire logic.

Parameters:
- DEPTH, 16, number of checkpoint entries (power of 2).
- PTR_W, 4, log2(DEPTH); tag width.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- alloc_valid_i  in  1  fetch allocates a checkpoint for a predicted cond branch
- alloc_pc_i  in  64  branch PC
- alloc_bhr_i  in  12  BHR before shifting in this prediction
- alloc_lochist_i  in  10  local history used for this prediction
- alloc_pred_i  in  1  final predicted direction
- alloc_ch_we_i  in  1  global_pred ^ local_pred at prediction time
- alloc_ch_ud_i  in  1  local_pred at prediction time
- alloc_ready_o  out  1  allocation accepted this cycle
- alloc_tag_o  out  PTR_W  tag of the entry written on accept (current tail index)
- res_valid_i  in  1  execute resolves a branch
- res_tag_i  in  PTR_W  tag of the resolved branch
- res_brdir_i  in  1  actual direction
- flush_i  in  1  pipeline-wide flush (exception/trap); empties queue
- rt_req_i  in  1  retire wants to commit the oldest cond branch
- rt_ack_o  out  1  head retired this cycle
- count_o  out  PTR_W+1  occupied entries
- bob_pc_r_o  out  64  PC of reported entry
- bob_bhr_r_o  out  12  history of reported entry
- bob_lochist_o  out  10  local history of reported entry
- bob_valid_r_o  out  1  recovery BHR on bob_bhr_r_o is valid
- bob_flush_o  out  1  recovery/flush pulse to predictor
- bpd_rt_we_o  out  1  retire write enable for local BHT
- bpd_rt_update_o  out  1  retire update for gshare and local PHT
- bpd_rt_brdir_o  out  1  actual direction of retired branch
- bpd_ch_we_o  out  1  stored alloc_ch_we of retired branch
- bpd_ch_brdir_o  out  1  stored alloc_ch_ud of retired branch

Behaviour:
- Reset (async, reset_n=0):
  - head = tail = 0 (PTR_W+1 bits incl. wrap bit); all entry valid/resolved bits = 0.
  - All outputs 0; alloc_tag_o = 0; alloc_ready_o = 1 once reset deasserts.
- Entry fields: valid, resolved, pc, bhr, lochist, pred, ch_we, ch_ud, actual dir.
- Pointer rules:
  - full = (head/tail index equal, wrap bits differ).
  - empty = (head == tail).
  - count_o = tail − head, modulo 2^(PTR_W+1).
- mispredict_now = res_valid_i & entry[res_tag_i].valid & (res_brdir_i != entry[res_tag_i].pred).
- Resolve:
  - Only when the addressed entry is valid: set resolved, store actual dir.
  - Resolve to an invalid (squashed) tag is ignored.
- Allocate:
  - alloc_ready_o = !full & !mispredict_now & !flush_i (combinational).
  - On alloc_valid_i & alloc_ready_o: write entry at tail (valid=1, resolved=0), tail++.
  - Allocation when not ready is dropped; fetch re-presents it.
- Mispredict recovery:
  - Same cycle: tail <= res_tag_i+1, with the wrap bit carried from the head-relative position. Valid cleared on all younger entries.
  - Next cycle, 1-cycle pulse:
    - bob_flush_o = 1, bob_valid_r_o = 1;
    - bob_pc_r_o = entry.pc;
    - bob_bhr_r_o = {entry.bhr[10:0], res_brdir_i} (corrected history);
    - bob_lochist_o = entry.lochist;
    - all bpd_rt_*/bpd_ch_* outputs = 0.
- Retire:
  - rt_ack_o = rt_req_i & head valid & head resolved & !mispredict_now & !flush_i.
  - On ack: clear head valid, head++.
  - Next cycle, 1-cycle pulse:
    - bob_pc_r_o / bob_bhr_r_o / bob_lochist_o = head entry's stored values;
    - bpd_rt_we_o = bpd_rt_update_o = 1;
    - bpd_rt_brdir_o = actual dir; bpd_ch_we_o = ch_we; bpd_ch_brdir_o = ch_ud;
    - bob_flush_o = bob_valid_r_o = 0.
- Priority in one cycle: flush_i > mispredict recovery > retire. Allocate and correct resolve may coincide with retire. Retire of an entry and its resolve in the same cycle is not acked (resolved is registered).
- flush_i:
  - head = tail = 0; all valid cleared; queued resolve/retire/alloc ignored.
  - Next cycle: bob_flush_o = 1, bob_valid_r_o = 0, all update outputs 0.
- All bus outputs are registered. They return to 0 on cycles with no event. Single-cycle latency from event to report.
- Wrap-around: index wraps DEPTH-1 → 0 with wrap-bit toggle; full/empty are unambiguous.
- Reset mid-operation: immediate return to reset state; no pulse emitted.

Test Plan:
- Alloc 3 branches (pc 0x1000/0x1004/0x1008, bhr 0x0A5, pred 1), resolve tag1 dir 1, rt_req → no ack until tag0 resolved.
  - Resolve tag0 dir 1 → ack.
  - Next cycle: bpd_rt_update_o=1, bob_pc_r_o=0x1000, bpd_rt_brdir_o=1.
- Alloc tags 0..5, resolve tag2 dir 0 (pred 1) → count_o 6→3.
  - Next cycle: bob_flush_o=1, bob_valid_r_o=1, bob_pc_r_o=pc2, bob_bhr_r_o={bhr2[10:0],0}.
  - Next alloc_tag_o=3.
- Fill 16 entries → alloc_ready_o=0, count_o=16.
  - Retire 1 → ready=1; the 17th alloc gets tag 0 with wrap bit toggled.
- Same cycle: mispredict resolve of tag1 and alloc_valid_i → alloc_ready_o=0, alloc dropped, tail=2.
- flush_i with 5 entries and rt_req_i=1 → rt_ack_o=0, count_o=0 next cycle, bob_flush_o=1, bob_valid_r_o=0.
- Retire entry alloc'd with ch_we=1, ch_ud=0, actual dir 1 → bpd_ch_we_o=1, bpd_ch_brdir_o=0, bpd_rt_we_o=1.
  - Resolve to a squashed tag → no state change.
